// File: rtl/gpio_player_pkg.sv
// Shared register map, bit positions and player FSM states for gpio_pattern_player.
package gpio_player_pkg;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegCtrl   = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegOe     = 2'd3;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlFlush = 1;
  localparam int unsigned CtrlIrqEn = 2;

  localparam int unsigned StatusEmpty    = 0;
  localparam int unsigned StatusFull     = 1;
  localparam int unsigned StatusBusy     = 2;
  localparam int unsigned StatusOvf      = 3;
  localparam int unsigned StatusLevelLsb = 8;

  typedef enum logic [0:0] {StIdle, StPlay} player_state_e;

endpackage

// File: rtl/gpio_pattern_player_if.sv
// Wishbone slave bundle between the management SoC and gpio_pattern_player.
interface gpio_pattern_player_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/gpio_player_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued {hold,pattern} entries.
module gpio_player_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned LevelW = AddrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [LevelW-1:0] count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == LevelW'(Depth));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpio_pattern_player.sv
// Wishbone-programmed player that replays queued patterns onto user pins for 'hold' cycles each.
// Define GPIO_PLAYER_IRQ_EN to add the irq output and the CTRL IRQ_EN bit.
module gpio_pattern_player
  import gpio_player_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HOLD_W   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  gpio_pattern_player_if.slave wbs,
  output logic [WIDTH-1:0]     io_out,
  output logic [WIDTH-1:0]     io_oeb
`ifdef GPIO_PLAYER_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned EntryW = WIDTH + HOLD_W;
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic              ack_q;
  logic [31:0]       dat_o_q;
  logic              req, wr;
  logic [1:0]        reg_sel;
  logic              wr_data, wr_ctrl, wr_status, wr_oe, flush;
  logic              en_q, ovf_q;
  logic [WIDTH-1:0]  oe_q;
  logic [31:0]       rdata;

  logic [EntryW-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty, pop;
  logic [LevelW-1:0] fifo_level;
  logic [HOLD_W-1:0] hold;

  player_state_e     state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic              load;

  logic              unused_bits;
  assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

  // A held-high strobe is served once: the cycle after ack is ignored.
  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                     (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr        = req & wbs.wbs_we_i;
  assign reg_sel   = wbs.wbs_adr_i[3:2];
  assign wr_data   = wr & (reg_sel == RegData);
  assign wr_ctrl   = wr & (reg_sel == RegCtrl);
  assign wr_status = wr & (reg_sel == RegStatus);
  assign wr_oe     = wr & (reg_sel == RegOe);
  assign flush     = wr_ctrl & wbs.wbs_dat_i[CtrlFlush];

  gpio_player_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (wr_data),
    .wdata_i (wbs.wbs_dat_i[EntryW-1:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign hold = fifo_rdata[EntryW-1:WIDTH];

`ifdef GPIO_PLAYER_IRQ_EN
  logic irq_en_q, irq_q;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      oe_q    <= '0;
    end else begin
      ack_q   <= req;
      dat_o_q <= (req & ~wbs.wbs_we_i) ? rdata : '0;
      if (wr_ctrl) en_q <= wbs.wbs_dat_i[CtrlEn];
      if (wr_oe)   oe_q <= wbs.wbs_dat_i[WIDTH-1:0];
      // Overflow is judged on the pre-cycle count, so a same-cycle pop does not rescue the push.
      if (wr_data && fifo_full)                         ovf_q <= 1'b1;
      else if (wr_status && wbs.wbs_dat_i[StatusOvf])   ovf_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      RegData: rdata[WIDTH-1:0] = pat_q;
      RegCtrl: begin
        rdata[CtrlEn] = en_q;
`ifdef GPIO_PLAYER_IRQ_EN
        rdata[CtrlIrqEn] = irq_en_q;
`endif
      end
      RegStatus: begin
        rdata[StatusEmpty]                = fifo_empty;
        rdata[StatusFull]                 = fifo_full;
        rdata[StatusBusy]                 = (state_q == StPlay);
        rdata[StatusOvf]                  = ovf_q;
        rdata[StatusLevelLsb +: 8]        = 8'(fifo_level);
      end
      RegOe:   rdata[WIDTH-1:0] = oe_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_q && !fifo_empty && !flush) begin
          load    = 1'b1;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (flush || !en_q)      state_d = StIdle;
        else if (cnt_q != '0)    cnt_d   = cnt_q - 1'b1;
        else if (!fifo_empty)    load    = 1'b1;
        else                     state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // hold=0 plays for one cycle, same as hold=1.
    if (load) begin
      pop   = 1'b1;
      pat_d = fifo_rdata[WIDTH-1:0];
      cnt_d = (hold == '0) ? '0 : hold - 1'b1;
    end
  end

`ifdef GPIO_PLAYER_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wbs.wbs_dat_i[CtrlIrqEn];
      irq_q <= irq_en_q && (state_q == StPlay) && (state_d == StIdle) && fifo_empty;
    end
  end
  assign irq = irq_q;
`endif

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_o_q;
  assign io_out        = pat_q;
  assign io_oeb        = ~oe_q;

endmodule

// File: tb/tb_gpio_pattern_player.sv
// Directed self-checking bench for gpio_pattern_player (default 8-bit, 8-deep configuration).
module tb_gpio_pattern_player;

  localparam logic [31:0] A_DATA   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = 32'h3000_0004;
  localparam logic [31:0] A_STATUS = 32'h3000_0008;
  localparam logic [31:0] A_OE     = 32'h3000_000C;

  logic       clk;
  logic       rst;
  logic [7:0] io_out;
  logic [7:0] io_oeb;
`ifdef GPIO_PLAYER_IRQ_EN
  logic       irq;
`endif

  int n_pass;
  int n_total;

  gpio_pattern_player_if bus ();

  gpio_pattern_player #(
    .BASE_ADR (32'h3000_0000),
    .WIDTH    (8),
    .DEPTH    (8),
    .HOLD_W   (16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
`ifdef GPIO_PLAYER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic wb_access(input logic [31:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
    int t;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (bus.wbs_ack_o !== 1'b1 && t < 10);
    rd = bus.wbs_dat_o;
    n_total++;
    if (bus.wbs_ack_o !== 1'b1) $display("FAIL bus_ack adr=%h: ack=%b want 1", a, bus.wbs_ack_o);
    else n_pass++;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(a, 1'b1, d, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    wb_access(a, 1'b0, 32'h0, d);
  endtask

  task automatic wait_pattern(input logic [7:0] p);
    int t;
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (io_out !== p && t < 30);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (io_oeb !== 8'hFF) $display("FAIL reset_oeb: got %h want ff", io_oeb); else n_pass++;
    n_total++; if (io_out !== 8'h00) $display("FAIL reset_out: got %h want 00", io_out); else n_pass++;
    n_total++; if (bus.wbs_dat_o !== 32'h0) $display("FAIL reset_dat: got %h want 0", bus.wbs_dat_o); else n_pass++;
`ifdef GPIO_PLAYER_IRQ_EN
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
`endif
    bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = A_STATUS;
    repeat (3) begin
      @(posedge clk); #1;
      n_total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL no_stb_ack: got %b want 0", bus.wbs_ack_o); else n_pass++;
    end
    bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h3000_0010;
    repeat (2) begin
      @(posedge clk); #1;
      n_total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL adr_miss_ack: got %b want 0", bus.wbs_ack_o); else n_pass++;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL reset_status: got %h want 00000001", rd); else n_pass++;
    wb_read(A_CTRL, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", rd); else n_pass++;
    wb_write(A_OE, 32'hFF);
    n_total++; if (io_oeb !== 8'h00) $display("FAIL oe_write: got %h want 00", io_oeb); else n_pass++;
    wb_read(A_OE, rd);
    n_total++; if (rd !== 32'hFF) $display("FAIL oe_read: got %h want ff", rd); else n_pass++;
  endtask

  task automatic test_playback();
    logic [7:0]  seq [12];
    logic [31:0] rd;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    wb_write(A_CTRL, 32'h1);
    fork
      begin
        for (int i = 0; i < 12; i++) wb_write(A_DATA, (32'd4 << 8) | 32'(seq[i]));
      end
      begin
        wait_pattern(8'h01);
        for (int i = 0; i < 12; i++) begin
          for (int c = 0; c < 4; c++) begin
            if (i != 0 || c != 0) begin
              @(posedge clk); #2;
            end
            n_total++;
            if (io_out !== seq[i]) $display("FAIL play_step%0d_c%0d: got %h want %h", i, c, io_out, seq[i]);
            else n_pass++;
          end
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (io_out !== 8'h00) $display("FAIL play_idle_out: got %h want 00", io_out); else n_pass++;
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL play_idle_status: got %h want 00000001", rd); else n_pass++;
    wb_read(A_DATA, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL play_data_read: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    wb_write(A_CTRL, 32'h0);
    for (int k = 0; k < 9; k++) wb_write(A_DATA, (32'd1 << 8) | (32'h11 + 32'(k)));
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_080A) $display("FAIL ovf_status: got %h want 0000080a", rd); else n_pass++;
    wb_write(A_STATUS, 32'h8);
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0802) $display("FAIL ovf_clear: got %h want 00000802", rd); else n_pass++;
    wb_write(A_CTRL, 32'h1);
    wait_pattern(8'h11);
    n_total++; if (io_out !== 8'h11) $display("FAIL ovf_first: got %h want 11", io_out); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #2;
      n_total++;
      if (io_out !== 8'h11 + 8'(k)) $display("FAIL ovf_play%0d: got %h want %h", k, io_out, 8'h11 + 8'(k));
      else n_pass++;
    end
    repeat (3) begin
      @(posedge clk); #2;
      n_total++; if (io_out !== 8'h18) $display("FAIL ovf_ninth_dropped: got %h want 18", io_out); else n_pass++;
    end
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL ovf_drained: got %h want 00000001", rd); else n_pass++;
  endtask

  task automatic test_disable();
    logic [31:0] rd;
    wb_write(A_CTRL, 32'h0);
    wb_write(A_DATA, (32'd100 << 8) | 32'hC3);
    wb_write(A_DATA, (32'd2 << 8) | 32'h3C);
    wb_write(A_CTRL, 32'h1);
    wait_pattern(8'hC3);
    repeat (8) @(posedge clk);
    #1;
    wb_write(A_CTRL, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    n_total++; if (io_out !== 8'hC3) $display("FAIL dis_frozen: got %h want c3", io_out); else n_pass++;
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0100) $display("FAIL dis_status: got %h want 00000100", rd); else n_pass++;
    repeat (5) @(posedge clk);
    #2;
    n_total++; if (io_out !== 8'hC3) $display("FAIL dis_still_frozen: got %h want c3", io_out); else n_pass++;
    wb_write(A_CTRL, 32'h1);
    wait_pattern(8'h3C);
    n_total++; if (io_out !== 8'h3C) $display("FAIL dis_resume: got %h want 3c", io_out); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL dis_done_status: got %h want 00000001", rd); else n_pass++;
    n_total++; if (io_out !== 8'h3C) $display("FAIL dis_done_out: got %h want 3c", io_out); else n_pass++;
  endtask

  task automatic test_hold0_flush();
    logic [31:0] rd;
    wb_write(A_CTRL, 32'h0);
    wb_write(A_DATA, 32'h0000_00A5);
    wb_write(A_DATA, 32'h0000_005A);
    wb_write(A_DATA, (32'd50 << 8) | 32'h77);
    wb_write(A_CTRL, 32'h1);
    wait_pattern(8'hA5);
    n_total++; if (io_out !== 8'hA5) $display("FAIL h0_a5: got %h want a5", io_out); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (io_out !== 8'h5A) $display("FAIL h0_5a: got %h want 5a", io_out); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (io_out !== 8'h77) $display("FAIL h0_next: got %h want 77", io_out); else n_pass++;
    wb_write(A_DATA, (32'd5 << 8) | 32'h99);
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0104) $display("FAIL flush_pre_status: got %h want 00000104", rd); else n_pass++;
    wb_write(A_CTRL, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    wb_read(A_STATUS, rd);
    n_total++; if (rd !== 32'h0000_0001) $display("FAIL flush_status: got %h want 00000001", rd); else n_pass++;
    n_total++; if (io_out !== 8'h77) $display("FAIL flush_out_kept: got %h want 77", io_out); else n_pass++;
    wb_read(A_CTRL, rd);
    n_total++; if (rd !== 32'h1) $display("FAIL flush_selfclear: got %h want 1", rd); else n_pass++;
    wb_read(A_DATA, rd);
    n_total++; if (rd !== 32'h77) $display("FAIL flush_data_read: got %h want 77", rd); else n_pass++;
  endtask

`ifdef GPIO_PLAYER_IRQ_EN
  task automatic test_irq();
    int pulses;
    logic [7:0] at_irq;
    pulses = 0;
    at_irq = 8'h00;
    wb_write(A_CTRL, 32'h0);
    wb_write(A_DATA, (32'd2 << 8) | 32'h21);
    wb_write(A_DATA, (32'd2 << 8) | 32'h22);
    wb_write(A_CTRL, 32'h5);
    repeat (20) begin
      @(posedge clk); #2;
      if (irq === 1'b1) begin
        pulses++;
        at_irq = io_out;
      end
    end
    n_total++; if (pulses !== 1) $display("FAIL irq_count: got %0d want 1", pulses); else n_pass++;
    n_total++; if (at_irq !== 8'h22) $display("FAIL irq_when: got %h want 22", at_irq); else n_pass++;
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_playback();
    test_overflow();
    test_disable();
    test_hold0_flush();
`ifdef GPIO_PLAYER_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
